dcache_tagarray_arbiter: RTL and testbench
==========================================

// Module: dcache_tagarray_arbiter
// PURPOSE
//  Shares the single-ported dcache tag array between three requesters:
//  - load pipe L1 (read)
//  - store pipe (read)
//  - refill unit (write)
//  At most one access is granted per cycle. Refill has fixed priority, and a
//  per-port starvation counter protects the read ports from it. Load and
//  store reads alternate round-robin. Each read grant is tagged with a
//  1-cycle-later response valid, so the owning pipe knows the tag array
//  output is its own.
// PARAMETERS
//  TAGARRAY_ADDR_WIDTH  6   tag array index width
//  TAGARRAY_DATA_WIDTH  21  tag array entry width ({valid, tag})
//  STARVE_LIMIT         4   consecutive denied cycles before a read beats refill (>=1)
// PORTS
//  clock            in   1    single clock; all state updates on posedge
//  reset            in   1    synchronous, active-high reset
//  flush            in   1    pipeline flush; kills load-side requests and responses
//  ld_req_valid     in   1    load pipe read request
//  ld_req_ready     out  1    load read granted this cycle
//  ld_req_idx       in   TAGARRAY_ADDR_WIDTH  load read index
//  st_req_valid     in   1    store pipe read request
//  st_req_ready     out  1    store read granted this cycle
//  st_req_idx       in   TAGARRAY_ADDR_WIDTH  store read index
//  rf_req_valid     in   1    refill tag write request
//  rf_req_ready     out  1    refill write granted this cycle
//  rf_req_idx       in   TAGARRAY_ADDR_WIDTH  refill write index
//  rf_req_wdata     in   TAGARRAY_DATA_WIDTH  refill write data
//  tagarray_rd_en   out  1    array read enable
//  tagarray_wr_en   out  1    array write enable
//  tagarray_idx     out  TAGARRAY_ADDR_WIDTH  array index (read or write)
//  tagarray_wdata   out  TAGARRAY_DATA_WIDTH  array write data
//  ld_resp_valid    out  1    array read data this cycle belongs to load pipe
//  st_resp_valid    out  1    array read data this cycle belongs to store pipe
// BEHAVIOUR
//  - Handshake: *_ready is a combinational grant. Transfer (fire) = valid & ready.
//    Ready never depends on the port's own idx/wdata. Requesters hold valid until fire.
//  - At most one of ld/st/rf fires per cycle. Ready is 0 for any port not selected.
//  - Effective load valid: ldv = ld_req_valid & ~flush. While flush=1, ld_req_ready=0.
//  - Starvation counters ld_cnt, st_cnt, width $clog2(STARVE_LIMIT+1):
//    - port valid & not fired: increment, saturating at STARVE_LIMIT.
//    - fired or not valid: cleared to 0.
//    - ld_cnt also clears while flush=1.
//  - Starved condition: ld_st = ldv & (ld_cnt==STARVE_LIMIT);
//    st_st = st_req_valid & (st_cnt==STARVE_LIMIT).
//  - Selection order:
//    1) Any starved read wins. If both are starved, the rr-favoured one wins.
//    2) Otherwise rf_req_valid wins.
//    3) Otherwise, among ldv/st_req_valid, the rr-favoured one wins; if only one
//       is valid, that one wins.
//  - rr pointer: 0 = favour load, 1 = favour store.
//    - On a load fire, rr<=1. On a store fire, rr<=0. Otherwise rr holds.
//  - Array drive (combinational):
//    - tagarray_rd_en = ld_fire | st_fire
//    - tagarray_wr_en = rf_fire
//    - tagarray_idx = idx of the firing port, else 0
//    - tagarray_wdata = rf_req_wdata when rf_fire, else 0
//  - Read latency is 1 cycle.
//    - ld_resp_q <= ld_fire, st_resp_q <= st_fire.
//    - ld_resp_valid = ld_resp_q & ~flush (a flush in the response cycle kills it).
//    - st_resp_valid = st_resp_q; flush has no effect on store or refill.
//  - Reset (synchronous): rr=0, counters=0, resp regs=0. Reset overrides every
//    other update in the same cycle, including mid-starvation.
//  - All registered outputs are 0 in the cycle after reset. Combinational outputs
//    follow the inputs, and are 0 when no request is valid.
// TESTING
//  1. Assert reset with all valids high. Next cycle: ld/st_resp_valid=0, rr=0,
//     cnts=0. First post-reset grant goes to rf.
//  2. ld & st valid every cycle, rf=0. Grants are L,S,L,S...
//     ld_resp_valid/st_resp_valid alternate, 1 cycle behind.
//     tagarray_idx tracks ld_req_idx=5 / st_req_idx=9.
//  3. STARVE_LIMIT=4, rf & ld valid continuously. rf fires cycles 0-3, ld_cnt
//     reaches 4, ld fires cycle 4, ld_cnt clears, rf fires cycles 5-8, ld fires cycle 9.
//  4. ld fires (idx=3) at cycle t, flush=1 at t+1. ld_resp_valid=0 at t+1.
//     While flush=1: ld_req_ready=0 and a valid st is granted instead.
//  5. rf, ld, st all valid with cnts=0. rf_req_ready=1, tagarray_wr_en=1,
//     tagarray_wdata=rf_req_wdata, ld/st ready=0, both cnts increment to 1.
//  6. Both ld and st starved (cnt=4) with rr=1. st fires, then ld next cycle.
//     Reset asserted with cnts=3 clears them, and subsequent rf grants last 4 cycles.

Source files
------------

// File: rtl/dcache_tagarray_arbiter.sv
// Dcache tag array port arbiter: refill writes vs. load/store reads.
// Refill has priority; starvation counters and a load/store round-robin keep reads moving.
module dcache_tagarray_arbiter #(
    parameter int TAGARRAY_ADDR_WIDTH = 6,
    parameter int TAGARRAY_DATA_WIDTH = 21,
    parameter int STARVE_LIMIT        = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           ld_req_valid,
    output logic                           ld_req_ready,
    input  logic [TAGARRAY_ADDR_WIDTH-1:0] ld_req_idx,
    input  logic                           st_req_valid,
    output logic                           st_req_ready,
    input  logic [TAGARRAY_ADDR_WIDTH-1:0] st_req_idx,
    input  logic                           rf_req_valid,
    output logic                           rf_req_ready,
    input  logic [TAGARRAY_ADDR_WIDTH-1:0] rf_req_idx,
    input  logic [TAGARRAY_DATA_WIDTH-1:0] rf_req_wdata,
    output logic                           tagarray_rd_en,
    output logic                           tagarray_wr_en,
    output logic [TAGARRAY_ADDR_WIDTH-1:0] tagarray_idx,
    output logic [TAGARRAY_DATA_WIDTH-1:0] tagarray_wdata,
    output logic                           ld_resp_valid,
    output logic                           st_resp_valid
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic {
        RR_LD = 1'b0,
        RR_ST = 1'b1
    } rr_e;

    rr_e           rr_q, rr_d;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d;
    logic [CW-1:0] st_cnt_q, st_cnt_d;
    logic          ld_resp_q, ld_resp_d;
    logic          st_resp_q, st_resp_d;

    logic ldv, stv;
    logic ld_starved, st_starved;
    logic ld_fire, st_fire, rf_fire;

    // A flushed load request is invisible to the arbiter.
    assign ldv = ld_req_valid & ~flush;
    assign stv = st_req_valid;

    assign ld_starved = ldv & (ld_cnt_q == CNT_MAX);
    assign st_starved = stv & (st_cnt_q == CNT_MAX);

    always_comb begin
        ld_fire = 1'b0;
        st_fire = 1'b0;
        rf_fire = 1'b0;
        if (ld_starved && st_starved) begin
            if (rr_q == RR_ST) st_fire = 1'b1;
            else               ld_fire = 1'b1;
        end else if (ld_starved) begin
            ld_fire = 1'b1;
        end else if (st_starved) begin
            st_fire = 1'b1;
        end else if (rf_req_valid) begin
            rf_fire = 1'b1;
        end else if (ldv && stv) begin
            if (rr_q == RR_ST) st_fire = 1'b1;
            else               ld_fire = 1'b1;
        end else if (ldv) begin
            ld_fire = 1'b1;
        end else if (stv) begin
            st_fire = 1'b1;
        end
    end

    assign ld_req_ready = ld_fire;
    assign st_req_ready = st_fire;
    assign rf_req_ready = rf_fire;

    always_comb begin
        tagarray_rd_en = ld_fire | st_fire;
        tagarray_wr_en = rf_fire;
        tagarray_idx   = '0;
        tagarray_wdata = '0;
        unique case (1'b1)
            ld_fire: tagarray_idx = ld_req_idx;
            st_fire: tagarray_idx = st_req_idx;
            rf_fire: begin
                tagarray_idx   = rf_req_idx;
                tagarray_wdata = rf_req_wdata;
            end
            default: ;
        endcase
    end

    // Counters measure consecutive denied cycles and saturate at the limit.
    always_comb begin
        ld_cnt_d = '0;
        st_cnt_d = '0;
        if (ldv && !ld_fire) begin
            ld_cnt_d = (ld_cnt_q == CNT_MAX) ? CNT_MAX : ld_cnt_q + 1'b1;
        end
        if (stv && !st_fire) begin
            st_cnt_d = (st_cnt_q == CNT_MAX) ? CNT_MAX : st_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (ld_fire)      rr_d = RR_ST;
        else if (st_fire) rr_d = RR_LD;
    end

    assign ld_resp_d = ld_fire;
    assign st_resp_d = st_fire;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q      <= RR_LD;
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            ld_resp_q <= 1'b0;
            st_resp_q <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            ld_cnt_q  <= ld_cnt_d;
            st_cnt_q  <= st_cnt_d;
            ld_resp_q <= ld_resp_d;
            st_resp_q <= st_resp_d;
        end
    end

    // Flush in the response cycle discards the load's read data.
    assign ld_resp_valid = ld_resp_q & ~flush;
    assign st_resp_valid = st_resp_q;

endmodule

// File: tb/tb_dcache_tagarray_arbiter.sv
// Testbench for dcache_tagarray_arbiter: directed scenarios plus
// randomized traffic checked against a rule-level reference model.
module tb_dcache_tagarray_arbiter;

    localparam int AW  = 6;
    localparam int DW  = 21;
    localparam int LIM = 4;

    localparam int G_NONE = 0;
    localparam int G_LD   = 1;
    localparam int G_ST   = 2;
    localparam int G_RF   = 3;

    logic          clock = 1'b0;
    logic          reset, flush;
    logic          ld_req_valid, st_req_valid, rf_req_valid;
    logic          ld_req_ready, st_req_ready, rf_req_ready;
    logic [AW-1:0] ld_req_idx, st_req_idx, rf_req_idx;
    logic [DW-1:0] rf_req_wdata;
    logic          tagarray_rd_en, tagarray_wr_en;
    logic [AW-1:0] tagarray_idx;
    logic [DW-1:0] tagarray_wdata;
    logic          ld_resp_valid, st_resp_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state: plain integers following the arbitration rules.
    int m_rr, m_ldc, m_stc;
    bit m_ldr, m_str;
    int m_g;

    dcache_tagarray_arbiter #(
        .TAGARRAY_ADDR_WIDTH(AW),
        .TAGARRAY_DATA_WIDTH(DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .ld_req_valid(ld_req_valid),
        .ld_req_ready(ld_req_ready),
        .ld_req_idx(ld_req_idx),
        .st_req_valid(st_req_valid),
        .st_req_ready(st_req_ready),
        .st_req_idx(st_req_idx),
        .rf_req_valid(rf_req_valid),
        .rf_req_ready(rf_req_ready),
        .rf_req_idx(rf_req_idx),
        .rf_req_wdata(rf_req_wdata),
        .tagarray_rd_en(tagarray_rd_en),
        .tagarray_wr_en(tagarray_wr_en),
        .tagarray_idx(tagarray_idx),
        .tagarray_wdata(tagarray_wdata),
        .ld_resp_valid(ld_resp_valid),
        .st_resp_valid(st_resp_valid)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic r, input logic f, input logic lv,
                         input logic sv, input logic rv,
                         input logic [AW-1:0] li, input logic [AW-1:0] si,
                         input logic [AW-1:0] ri, input logic [DW-1:0] wd);
        reset        = r;
        flush        = f;
        ld_req_valid = lv;
        st_req_valid = sv;
        rf_req_valid = rv;
        ld_req_idx   = li;
        st_req_idx   = si;
        rf_req_idx   = ri;
        rf_req_wdata = wd;
        #1;
    endtask

    function automatic int dut_grant();
        int n;
        n = int'(ld_req_ready) + int'(st_req_ready) + int'(rf_req_ready);
        if (n > 1) return 9;
        if (ld_req_ready) return G_LD;
        if (st_req_ready) return G_ST;
        if (rf_req_ready) return G_RF;
        return G_NONE;
    endfunction

    task automatic model_eval();
        bit ldv, lds, sts;
        ldv = ld_req_valid && !flush;
        lds = ldv && (m_ldc == LIM);
        sts = st_req_valid && (m_stc == LIM);
        if (lds && sts)                 m_g = m_rr ? G_ST : G_LD;
        else if (lds)                   m_g = G_LD;
        else if (sts)                   m_g = G_ST;
        else if (rf_req_valid)          m_g = G_RF;
        else if (ldv && st_req_valid)   m_g = m_rr ? G_ST : G_LD;
        else if (ldv)                   m_g = G_LD;
        else if (st_req_valid)          m_g = G_ST;
        else                            m_g = G_NONE;
    endtask

    task automatic tick();
        bit ldv;
        model_eval();
        ldv = ld_req_valid && !flush;
        @(posedge clock);
        if (reset) begin
            m_rr = 0; m_ldc = 0; m_stc = 0; m_ldr = 0; m_str = 0;
        end else begin
            m_ldr = (m_g == G_LD);
            m_str = (m_g == G_ST);
            if (m_g == G_LD) m_rr = 1;
            else if (m_g == G_ST) m_rr = 0;
            m_ldc = (ldv && m_g != G_LD) ? ((m_ldc + 1 > LIM) ? LIM : m_ldc + 1) : 0;
            m_stc = (st_req_valid && m_g != G_ST) ? ((m_stc + 1 > LIM) ? LIM : m_stc + 1) : 0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [DW-1:0] wd;
        // Load fires during the reset cycle; reset must still clear its response.
        drive(1, 0, 1, 0, 0, 6'd7, 0, 0, 0);
        tick();
        drive(1, 0, 1, 1, 1, 6'd7, 6'd8, 6'd9, 21'h1);
        tick();
        wd = DW'($urandom);
        drive(0, 0, 1, 1, 1, 6'd7, 6'd8, 6'd33, wd);
        checks++;
        if (ld_resp_valid !== 1'b0 || st_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp ld=%b st=%b want 0 0", ld_resp_valid, st_resp_valid);
        end
        checks++;
        if (dut_grant() != G_RF) begin
            failures++;
            $display("FAIL reset_first_grant got=%0d want=%0d", dut_grant(), G_RF);
        end
        checks++;
        if (tagarray_wr_en !== 1'b1 || tagarray_idx !== 6'd33 || tagarray_wdata !== wd) begin
            failures++;
            $display("FAIL reset_array wr=%b idx=%0d wd=%h want 1 33 %h",
                     tagarray_wr_en, tagarray_idx, tagarray_wdata, wd);
        end
        tick();
        drive(0, 0, 0, 0, 0, 6'd7, 6'd8, 6'd9, wd);
        checks++;
        if ({ld_req_ready, st_req_ready, rf_req_ready, tagarray_rd_en, tagarray_wr_en} !== 5'b0
            || tagarray_idx !== '0 || tagarray_wdata !== '0) begin
            failures++;
            $display("FAIL idle_outputs rdy=%b%b%b rd=%b wr=%b idx=%0d wd=%h want all 0",
                     ld_req_ready, st_req_ready, rf_req_ready, tagarray_rd_en,
                     tagarray_wr_en, tagarray_idx, tagarray_wdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 1, 0, 6'd5, 6'd9, 6'd1, 0);
            checks++;
            if (dut_grant() != ((i % 2) ? G_ST : G_LD) || tagarray_idx !== ((i % 2) ? 6'd9 : 6'd5)
                || tagarray_rd_en !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant cyc=%0d got=%0d idx=%0d want=%0d idx=%0d",
                         i, dut_grant(), tagarray_idx, (i % 2) ? G_ST : G_LD, (i % 2) ? 9 : 5);
            end
            checks++;
            if (ld_resp_valid !== (i > 0 && (i % 2) == 1) || st_resp_valid !== (i > 0 && (i % 2) == 0)) begin
                failures++;
                $display("FAIL rr_resp cyc=%0d ld=%b st=%b want %b %b", i, ld_resp_valid,
                         st_resp_valid, i > 0 && (i % 2) == 1, i > 0 && (i % 2) == 0);
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        int exp_seq[10];
        exp_seq = '{G_RF, G_RF, G_RF, G_RF, G_LD, G_RF, G_RF, G_RF, G_RF, G_LD};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 0, 1, 6'd2, 0, 6'd4, 21'h5);
            checks++;
            if (dut_grant() != exp_seq[i]) begin
                failures++;
                $display("FAIL starve_seq cyc=%0d got=%0d want=%0d", i, dut_grant(), exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 0, 1, 0, 0, 6'd3, 6'd9, 0, 0);
        checks++;
        if (dut_grant() != G_LD || tagarray_idx !== 6'd3) begin
            failures++;
            $display("FAIL flush_ldfire got=%0d idx=%0d want=%0d idx=3", dut_grant(), tagarray_idx, G_LD);
        end
        tick();
        drive(0, 1, 1, 1, 0, 6'd3, 6'd9, 0, 0);
        checks++;
        if (ld_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_kill_resp got=%b want=0", ld_resp_valid);
        end
        checks++;
        if (ld_req_ready !== 1'b0 || st_req_ready !== 1'b1 || tagarray_idx !== 6'd9) begin
            failures++;
            $display("FAIL flush_st_grant ld=%b st=%b idx=%0d want 0 1 9",
                     ld_req_ready, st_req_ready, tagarray_idx);
        end
        tick();
        drive(0, 1, 1, 1, 0, 6'd3, 6'd9, 0, 0);
        checks++;
        if (st_resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_st_resp got=%b want=1", st_resp_valid);
        end
        tick();
        drive(0, 0, 1, 1, 0, 6'd3, 6'd9, 0, 0);
        checks++;
        if (dut_grant() != G_LD || ld_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_after got=%0d ldresp=%b want=%0d 0", dut_grant(), ld_resp_valid, G_LD);
        end
        tick();
    endtask

    task automatic test_priority();
        int exp_seq[6];
        logic [DW-1:0] wd;
        exp_seq = '{G_RF, G_RF, G_RF, G_RF, G_LD, G_ST};
        do_reset();
        wd = DW'($urandom);
        drive(0, 0, 1, 1, 1, 6'd1, 6'd2, 6'd60, wd);
        checks++;
        if (rf_req_ready !== 1'b1 || tagarray_wr_en !== 1'b1 || tagarray_wdata !== wd
            || ld_req_ready !== 1'b0 || st_req_ready !== 1'b0 || tagarray_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL prio_rf rf=%b wr=%b wd=%h ld=%b st=%b rd=%b want 1 1 %h 0 0 0",
                     rf_req_ready, tagarray_wr_en, tagarray_wdata, ld_req_ready,
                     st_req_ready, tagarray_rd_en, wd);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 1, 1, 6'd1, 6'd2, 6'd60, wd);
            checks++;
            if (dut_grant() != exp_seq[i]) begin
                failures++;
                $display("FAIL prio_seq cyc=%0d got=%0d want=%0d", i, dut_grant(), exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_both_starved();
        int exp_a[6];
        int exp_b[6];
        exp_a = '{G_RF, G_RF, G_RF, G_RF, G_ST, G_LD};
        exp_b = '{G_RF, G_RF, G_RF, G_RF, G_LD, G_ST};
        do_reset();
        drive(0, 0, 1, 0, 0, 6'd1, 6'd2, 6'd3, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 1, 1, 6'd1, 6'd2, 6'd3, 21'h7);
            checks++;
            if (dut_grant() != exp_a[i]) begin
                failures++;
                $display("FAIL both_starved cyc=%0d got=%0d want=%0d", i, dut_grant(), exp_a[i]);
            end
            tick();
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 1, 6'd1, 6'd2, 6'd3, 21'h7);
            tick();
        end
        // Counters are at 3 here; reset must zero them despite the denial.
        drive(1, 0, 1, 1, 1, 6'd1, 6'd2, 6'd3, 21'h7);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 1, 1, 6'd1, 6'd2, 6'd3, 21'h7);
            checks++;
            if (dut_grant() != exp_b[i]) begin
                failures++;
                $display("FAIL reset_mid_starve cyc=%0d got=%0d want=%0d", i, dut_grant(), exp_b[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic lv, sv, rv, f, r;
        logic [AW-1:0] li, si, ri, eidx;
        logic [DW-1:0] wd, ewd;
        lv = 0; sv = 0; rv = 0;
        li = 0; si = 0; ri = 0; wd = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            // Requesters hold valid until they fire, then maybe issue anew.
            if (!lv) begin lv = ($urandom_range(0, 3) != 0); li = AW'($urandom); end
            if (!sv) begin sv = ($urandom_range(0, 3) != 0); si = AW'($urandom); end
            if (!rv) begin rv = ($urandom_range(0, 2) != 0); ri = AW'($urandom); wd = DW'($urandom); end
            f = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 59) == 0);
            drive(r, f, lv, sv, rv, li, si, ri, wd);
            model_eval();
            eidx = (m_g == G_LD) ? li : (m_g == G_ST) ? si : (m_g == G_RF) ? ri : '0;
            ewd  = (m_g == G_RF) ? wd : '0;
            checks++;
            if (dut_grant() != m_g) begin
                failures++;
                $display("FAIL rand_grant cyc=%0d got=%0d want=%0d", i, dut_grant(), m_g);
            end
            checks++;
            if (tagarray_rd_en !== (m_g == G_LD || m_g == G_ST) || tagarray_wr_en !== (m_g == G_RF)
                || tagarray_idx !== eidx || tagarray_wdata !== ewd) begin
                failures++;
                $display("FAIL rand_array cyc=%0d rd=%b wr=%b idx=%0d wd=%h want idx=%0d wd=%h",
                         i, tagarray_rd_en, tagarray_wr_en, tagarray_idx, tagarray_wdata, eidx, ewd);
            end
            checks++;
            if (ld_resp_valid !== (m_ldr && !f) || st_resp_valid !== m_str) begin
                failures++;
                $display("FAIL rand_resp cyc=%0d ld=%b st=%b want %b %b",
                         i, ld_resp_valid, st_resp_valid, m_ldr && !f, m_str);
            end
            tick();
            if (m_g == G_LD) lv = 0;
            if (m_g == G_ST) sv = 0;
            if (m_g == G_RF) rv = 0;
        end
    endtask

    initial begin
        m_rr = 0; m_ldc = 0; m_stc = 0; m_ldr = 0; m_str = 0; m_g = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_round_robin();
        test_starvation();
        test_flush();
        test_priority();
        test_both_starved();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
